// File: rtl/fifo_pkg.sv
// Shared types and default geometry for the RAM-backed FIFO controller and its output buffer.
package fifo_pkg;
  localparam int WIDTH = 32;
  localparam int ADDR  = 10;
  localparam int DEPTH = 1024;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } out_state_e;

  typedef logic [ADDR-1:0] ptr_t;

  function automatic logic [1:0] occ_of(out_state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// Two-slot registered output buffer that absorbs the RAM read latency; head slot drives m_data.
module fifo_out_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arrive,
  input  logic [WIDTH-1:0] din,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ,
  output logic [1:0]       state_dbg
);
  import fifo_pkg::*;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    m_valid = (state_q != EMPTY);
    pop     = m_valid && m_ready;
    case (state_q)
      EMPTY: begin
        if (arrive) begin
          head_d  = din;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({arrive, pop})
          2'b10: begin
            tail_d  = din;
            state_d = TWO;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = din;
          default: ;
        endcase
      end
      TWO: begin
        // The issue rule never lets a word arrive into TWO without a pop.
        if (pop) begin
          head_d = tail_q;
          if (arrive) tail_d  = din;
          else        state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign m_data    = head_q;
  assign occ       = occ_of(state_q);
  assign state_dbg = state_q;
endmodule

// File: rtl/simple_dual_port_ram.sv
// Behavioural stand-in for the simple dual-port RAM IP: port A writes, port B registered read.
module simple_dual_port_ram #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 10
) (
  input  logic             clka,
  input  logic             ena,
  input  logic             wea,
  input  logic [ADDR-1:0]  addra,
  input  logic [WIDTH-1:0] dina,
  input  logic             clkb,
  input  logic             enb,
  input  logic [ADDR-1:0]  addrb,
  output logic [WIDTH-1:0] doutb
);
  logic [WIDTH-1:0] mem [2**ADDR];

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (enb) doutb <= mem[addrb];
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a simple dual-port RAM: pointers, occupancy, read-ahead issue and FWFT output.
module ram_fifo_ctrl #(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int ADDR  = fifo_pkg::ADDR,
  parameter int DEPTH = fifo_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [ADDR+1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [ADDR-1:0]  ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_enb,
  output logic [ADDR-1:0]  ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb,
  output logic [1:0]       dbg_out_state
);
  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   ram_cnt_q, ram_cnt_d;
  logic            inflight_q, inflight_d;
  logic            wr, rd, pop;
  logic [1:0]      occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    s_ready = (ram_cnt_q != DEPTH_C);
    wr      = s_valid && s_ready;
    pop     = m_valid && m_ready;
    // Issue only if the word has a guaranteed slot when it lands; m_ready feeds this for full rate.
    rd      = (ram_cnt_q != '0) &&
              (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    wr_ptr_d   = wr_ptr_q + ADDR'(wr);
    rd_ptr_d   = rd_ptr_q + ADDR'(rd);
    inflight_d = rd;
    ram_cnt_d  = ram_cnt_q;
    case ({wr, rd})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ;
    endcase
    count = (ADDR+2)'(ram_cnt_q) + (ADDR+2)'(inflight_q) + (ADDR+2)'(occ);
  end

  assign full      = ~s_ready;
  assign empty     = (count == '0);
  assign ram_ena   = wr;
  assign ram_wea   = wr;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = s_data;
  assign ram_enb   = rd;
  assign ram_addrb = rd_ptr_q;

  fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .arrive    (inflight_q),
    .din       (ram_doutb),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .occ       (occ),
    .state_dbg (dbg_out_state)
  );
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Single-clock FIFO controller that drives the `simple_dual_port_ram` IP as its storage array. It accepts a valid/ready write stream and generates RAM port A writes. It issues RAM port B reads ahead of the consumer and absorbs the RAM's 1-cycle read latency in a 2-entry output buffer. The result is a first-word-fall-through valid/ready read stream at full throughput. Upstream producers push into it; downstream consumers see a registered `m_data`.

## Interface
Parameters:
- `WIDTH`, 32, data width; must match RAM `dina`/`doutb`.
- `ADDR`, 10, RAM address width.
- `DEPTH`, 1024, RAM word count; must equal 2**ADDR.

Ports:
- `clk`  in  1  single clock; RAM `clka` and `clkb` are both tied to it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  write request.
- `s_ready`  out  1  write accepted when `s_valid & s_ready`.
- `s_data`  in  WIDTH  write data.
- `m_valid`  out  1  read data available.
- `m_ready`  in  1  consumer accepts when `m_valid & m_ready`.
- `m_data`  out  WIDTH  head-of-FIFO data, registered.
- `count`  out  ADDR+2  total words held (RAM + in-flight + output buffer).
- `full`  out  1  equals `~s_ready`.
- `empty`  out  1  equals `count == 0`.
- `ram_ena`, `ram_wea`  out  1  port A enable/write; both equal the write handshake.
- `ram_addra`  out  ADDR  write pointer.
- `ram_dina`  out  WIDTH  equals `s_data`.
- `ram_enb`  out  1  read issue.
- `ram_addrb`  out  ADDR  read pointer.
- `ram_doutb`  in  WIDTH  RAM read data, valid the cycle after the address is sampled.

## Operation
- `wr_ptr`, `rd_ptr` are ADDR bits wide, increment by 1, and wrap DEPTH-1 → 0 naturally.
- `ram_cnt` (ADDR+1 bits) counts words written but not yet read out of the RAM.
  - Increments on a write; decrements on a read issue; unchanged when both happen in one cycle.
- `s_ready = (ram_cnt != DEPTH)`. It is a function of registers only; no dependency on `s_valid`.
- `inflight` (1 bit) is set by a read issue and cleared when the data lands.
- Output buffer FSM, two registered slots, head slot drives `m_data`. States:
  - EMPTY: `m_valid` = 0.
  - ONE: `m_valid` = 1.
  - TWO: `m_valid` = 1.
- FSM transitions on arrival (`inflight` set in the previous cycle) and pop (`m_valid & m_ready`):
  - arrival only: +1.
  - pop only: −1.
  - both: unchanged; the arrival fills the slot freed by the pop.
  - Arrival into EMPTY, or into ONE together with a pop, goes to the head slot.
- Read issue rule: `ram_enb = (ram_cnt != 0) && (occ + inflight - pop < 2)`, where `occ` is 0/1/2 from the FSM state.
  - The combinational path `m_ready` → `ram_enb` is intentional; it gives one word per cycle sustained.
- `count = ram_cnt + inflight + occ`. Maximum is DEPTH+2.
- The same RAM address is never read and written in one cycle, because a read requires `ram_cnt != 0` from committed writes. RAM collision mode is therefore irrelevant.

## Timing
- Reset values:
  - `s_ready` = 1, `full` = 0.
  - `m_valid` = 0, `m_data` = 0.
  - `count` = 0, `empty` = 1.
  - `ram_enb` = 0, `ram_ena` = 0, `ram_wea` = 0.
  - `ram_addra` = 0, `ram_addrb` = 0.
  - `inflight` = 0, FSM = EMPTY.
- Write→read latency: a word accepted at edge k into an empty FIFO is read (`ram_enb` sampled) at edge k+1 and captured at edge k+2. `m_valid` is high after edge k+2.
- Throughput: one write and one pop per cycle sustained indefinitely once primed.
- Full: `s_ready` drops in the cycle after the write that makes `ram_cnt == DEPTH`. It rises in the cycle after the next read issue.
- Reset mid-operation clears all state asynchronously. RAM contents are not cleared and are never observed without a fresh write.

## Structure
- Shared package `fifo_pkg`:
  - `WIDTH`/`ADDR`/`DEPTH` defaults, consistent with `defines.sv`.
  - typedef `out_state_e` {EMPTY, ONE, TWO}.
  - typedef `ptr_t` (logic [ADDR-1:0]).
- One natural sub-module, `fifo_out_buf`: the 2-slot output buffer and FSM. It takes arrival and data in, and produces `m_valid`/`m_data` and `occ`.
- The top-level `ram_fifo_ctrl` holds pointers, `ram_cnt`, `inflight` and the issue logic.
- The testbench instantiates `simple_dual_port_ram` beside the controller.

## Test plan
- Reset → `s_ready` = 1, `m_valid` = 0, `count` = 0, `empty` = 1, all RAM enables 0.
- Write 32'hA5A5_0001 at edge k with `m_ready` = 0:
  - `ram_enb` is high in the following cycle.
  - `m_valid` rises after edge k+2 with `m_data` = 32'hA5A5_0001.
  - It is held until the pop.
- `m_ready` = 0 with 1026 writes of data i:
  - `s_ready` goes low after the 1026th accept.
  - `count` = 1026 and `full` = 1.
  - Then drain: `m_data` = 0..1025 in order, with `s_ready` rising one cycle after the first pop.
- Continuous stream, both sides always ready, 3000 words of data i:
  - one `m_valid & m_ready` every cycle after the 2-cycle prime.
  - output equals 0..2999 in order; pointers wrap twice.
- Random `s_valid` and `m_ready`, 10 000 words checked against a scoreboard queue:
  - no loss or duplication.
  - `count` equals the scoreboard size every cycle.
- `rst_n` asserted mid-stream with `count` = 7:
  - all outputs return to reset values asynchronously.
  - a new word 32'hDEAD_BEEF is the first and only word returned afterward.
